// File: rtl/banana_sprite_blitter.sv
// Draws one SPR_W x SPR_H banana sprite into the framebuffer: ROM fetch,
// palette lookup, transparency and edge clipping, handshaked pixel writes.
module banana_sprite_blitter #(
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int FRAMES = 4,
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int ROM_AW = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [8:0]        pos_y,
  input  logic [1:0]        frame,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [2:0]        pix_index,
  input  logic [15:0]       pix_color,
  output logic [18:0]       fb_addr,
  output logic [15:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [9:0]    pos_x_r;
  logic [8:0]    pos_y_r;
  logic [FW-1:0] frame_r;
  logic [2:0]    pix_q;
  logic [10:0]   x_sum;
  logic [9:0]    y_sum;
  logic [18:0]   fb_addr_nxt;
  logic          clipped, transparent, last_pix;
  logic          advance, capture;

  assign rom_addr    = ROM_AW'(int'(frame_r) * SPR_W * SPR_H + int'(row) * SPR_W + int'(col));
  assign x_sum       = {1'b0, pos_x_r} + 11'(col);
  assign y_sum       = {1'b0, pos_y_r} + 10'(row);
  assign clipped     = (int'(x_sum) >= FB_W) || (int'(y_sum) >= FB_H);
  assign fb_addr_nxt = 19'(int'(y_sum) * FB_W + int'(x_sum));
  assign transparent = (rom_data == 3'd0) || (rom_data == 3'd6) || (rom_data == 3'd7);
  assign last_pix    = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));
  // The ROM word is only valid during READ, so the palette sees it live there
  // and a held copy otherwise.
  assign pix_index   = (state == READ) ? rom_data : pix_q;

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = READ;
      READ: begin
        if (transparent || clipped) begin
          advance = 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: if (fb_ready) advance = 1'b1;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (advance) state_nxt = last_pix ? DONE : FETCH;
  end

  // Status strobes are registered from the next state so they line up with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fb_we   <= 1'b0;
      col     <= '0;
      row     <= '0;
      pos_x_r <= '0;
      pos_y_r <= '0;
      frame_r <= '0;
      pix_q   <= '0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      fb_we <= (state_nxt == WRITE);
      if (state == IDLE && start) begin
        pos_x_r <= pos_x;
        pos_y_r <= pos_y;
        frame_r <= FW'(frame);
        col     <= '0;
        row     <= '0;
      end
      if (advance) begin
        if (col == CW'(SPR_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (state == READ) pix_q <= rom_data;
      if (capture) begin
        fb_addr <= fb_addr_nxt;
        fb_data <= pix_color;
      end
    end
  end

endmodule

// File: tb/tb_banana_sprite_blitter.sv
// Self-checking bench for banana_sprite_blitter: ROM and palette models, a
// write monitor, and a pixel-list reference model built from the sprite rules.
module tb_banana_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_n, start, busy, done, fb_we, fb_ready;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [1:0]  frame;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_data = 3'd0;
  logic [2:0]  pix_index;
  logic [15:0] pix_color, fb_data;
  logic [18:0] fb_addr;

  int checks = 0;
  int errors = 0;

  banana_sprite_blitter dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .frame(frame), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_index(pix_index), .pix_color(pix_color), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 Clk = ~Clk;

  logic [2:0] rom_mem [0:1023];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [15:0] pal(input logic [2:0] i);
    case (i)
      3'd1: return 16'hFFE0;
      3'd2: return 16'hFEA0;
      3'd3: return 16'hE5C0;
      3'd4: return 16'hD4A0;
      3'd5: return 16'h8A20;
      default: return 16'h0000;
    endcase
  endfunction
  assign pix_color = pal(pix_index);

  // Monitor: accepted writes, stall cycles, held-value stability, done pulses.
  logic [18:0] got_addr [$];
  logic [15:0] got_data [$];
  int stall_cnt = 0, unstable_cnt = 0, done_cnt = 0;
  bit prev_stall = 1'b0;
  logic [18:0] hold_addr = '0;
  logic [15:0] hold_data = '0;
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (prev_stall && (!fb_we || fb_addr !== hold_addr || fb_data !== hold_data))
        unstable_cnt++;
      if (fb_we && fb_ready) begin
        got_addr.push_back(fb_addr);
        got_data.push_back(fb_data);
      end
      if (done) done_cnt++;
      prev_stall = fb_we && !fb_ready;
      if (prev_stall) begin
        hold_addr = fb_addr;
        hold_data = fb_data;
        stall_cnt++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic [18:0] exp_addr [$];
  logic [15:0] exp_data [$];
  logic [9:0]  first_rom;
  int wbase, sbase, dbase, ubase;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every sprite pixel that is opaque and lands on screen, in scan order.
  task automatic buildExpected(input int fr, input int px, input int py);
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        logic [2:0] idx;
        int x, y;
        idx = rom_mem[fr * 256 + r * 16 + c];
        x = px + c;
        y = py + r;
        if (idx != 3'd0 && idx != 3'd6 && idx != 3'd7 && x < 640 && y < 480) begin
          exp_addr.push_back(19'(y * 640 + x));
          exp_data.push_back(pal(idx));
        end
      end
  endtask

  task automatic snapshot();
    wbase = got_addr.size();
    sbase = stall_cnt;
    dbase = done_cnt;
    ubase = unstable_cnt;
  endtask

  // mode 0: fb_ready held high; 1: random fb_ready; 2: five stall cycles on first write
  task automatic applyStimulus(input int fr, input int px, input int py, input int mode,
                               input bit perturb, output int done_cyc);
    int cyc, stall_left;
    buildExpected(fr, px, py);
    snapshot();
    stall_left = (mode == 2) ? 5 : 0;
    frame = 2'(fr); pos_x = 10'(px); pos_y = 9'(py); fb_ready = 1'b1; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    cyc = 1;
    first_rom = rom_addr;
    while (!done && cyc < 5000) begin
      if (mode == 1) fb_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && fb_we && stall_left > 0) begin
        fb_ready = 1'b0;
        stall_left--;
      end else fb_ready = 1'b1;
      if (perturb && cyc >= 5) begin
        start = 1'b1;
        pos_x = 10'($urandom); pos_y = 9'($urandom); frame = 2'($urandom);
      end
      @(posedge Clk); #1;
      cyc++;
    end
    start = 1'b0;
    fb_ready = 1'b1;
    done_cyc = done ? cyc : -1;
  endtask

  task automatic verifyDraw(input string tag, input int done_cyc, input int exp_stalls);
    int nw, stalls;
    repeat (3) begin @(posedge Clk); #1; end
    nw = got_addr.size() - wbase;
    stalls = stall_cnt - sbase;
    checkOutput({tag, "_done_cycle"}, done_cyc, 513 + exp_addr.size() + stalls);
    if (exp_stalls >= 0) checkOutput({tag, "_stalls"}, stalls, exp_stalls);
    checkOutput({tag, "_write_count"}, nw, exp_addr.size());
    for (int i = 0; i < nw && i < exp_addr.size(); i++) begin
      checkOutput({tag, "_addr"}, got_addr[wbase + i], exp_addr[i]);
      checkOutput({tag, "_data"}, got_data[wbase + i], exp_data[i]);
    end
    checkOutput({tag, "_done_pulses"}, done_cnt - dbase, 1);
    checkOutput({tag, "_busy_after"}, busy, 1'b0);
    checkOutput({tag, "_stable"}, unstable_cnt - ubase, 0);
  endtask

  initial begin
    int dc, fr, px, py, cyc;
    Reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1;
    pos_x = '0; pos_y = '0; frame = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'(i[0] ? 3 : 5);
    #12;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_we", fb_we, 1'b0);
    checkOutput("rst_rom_addr", rom_addr, 10'd0);
    checkOutput("rst_pix_index", pix_index, 3'd0);
    checkOutput("rst_fb_addr", fb_addr, 19'd0);
    checkOutput("rst_fb_data", fb_data, 16'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    $display("[TB] opaque frame 0 at origin");
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'd4;
    applyStimulus(0, 0, 0, 0, 1'b0, dc);
    checkOutput("t1_done_769", dc, 769);
    verifyDraw("t1", dc, 0);

    $display("[TB] transparent frame 2");
    for (int i = 512; i < 768; i++) rom_mem[i] = 3'd0;
    applyStimulus(2, 100, 50, 0, 1'b0, dc);
    checkOutput("t2_first_rom_addr", first_rom, 10'd512);
    checkOutput("t2_done_513", dc, 513);
    verifyDraw("t2", dc, 0);

    $display("[TB] clipped at bottom-right corner");
    for (int i = 256; i < 512; i++) rom_mem[i] = 3'($urandom_range(1, 5));
    applyStimulus(1, 632, 476, 0, 1'b0, dc);
    checkOutput("t3_writes_32", exp_addr.size(), 32);
    verifyDraw("t3", dc, 0);

    $display("[TB] five-cycle stall on first write");
    for (int i = 768; i < 1024; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[768] = 3'd2;
    applyStimulus(3, 10, 20, 2, 1'b0, dc);
    verifyDraw("t4", dc, 5);

    $display("[TB] start and position changes while busy");
    applyStimulus(3, 300, 200, 0, 1'b1, dc);
    verifyDraw("t5", dc, 0);

    $display("[TB] reset mid-draw at pixel 37");
    snapshot();
    frame = 2'd0; pos_x = '0; pos_y = '0; fb_ready = 1'b1; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 113) begin @(posedge Clk); #1; cyc++; end
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_we", fb_we, 1'b0);
    checkOutput("t6_fb_addr", fb_addr, 19'd0);
    checkOutput("t6_fb_data", fb_data, 16'd0);
    checkOutput("t6_rom_addr", rom_addr, 10'd0);
    checkOutput("t6_pix_index", pix_index, 3'd0);
    repeat (3) begin @(posedge Clk); #1; end
    Reset_n = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    checkOutput("t6_writes_before_reset", got_addr.size() - wbase, 37);
    checkOutput("t6_no_done", done_cnt - dbase, 0);
    checkOutput("t6_idle_we", fb_we, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b0, dc);
    verifyDraw("t6_restart", dc, 0);

    $display("[TB] randomized draws");
    for (int n = 0; n < 5; n++) begin
      for (int i = 256; i < 1024; i++) rom_mem[i] = 3'($urandom_range(0, 7));
      fr = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: px = $urandom_range(0, 639);
        1: px = $urandom_range(620, 639);
        default: px = $urandom_range(1000, 1023);
      endcase
      py = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 479) : $urandom_range(460, 511);
      applyStimulus(fr, px, py, (n % 2 == 0) ? 1 : 0, 1'b0, dc);
      verifyDraw("rand", dc, (n % 2 == 0) ? -1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
